// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Divide-by-zero result: quotient DBZ_Q, remainder equal to the dividend.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] DBZ_Q = 32'd0;

  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shift the dividend MSB into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem,
  input  logic             dividend_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] divisor_ext;
  logic           rem_top_unused;

  // The remainder is always below the divisor, so its top bit is zero here.
  assign rem_top_unused = rem[WIDTH];
  assign rem_sh         = {rem[WIDTH-1:0], dividend_msb};
  assign divisor_ext    = {1'b0, divisor};

  always_comb begin
    q_bit    = 1'b0;
    rem_next = rem_sh;
    if (rem_sh >= divisor_ext) begin
      q_bit    = 1'b1;
      rem_next = rem_sh - divisor_ext;
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned divider: one quotient bit per clock, valid/ready on
// both the operand and the result side.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | in_ready high, waiting for operands
//   CALC  | one restoring step per clock, step counter counts down to 0
//   DONE  | out_valid high, q/r/div_by_zero held until the consumer takes them
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] quot_next;
  logic             q_bit;
  logic [CW-1:0]    cnt;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem),
    .dividend_msb (dividend[WIDTH-1]),
    .divisor      (divisor),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  assign quot_next = {quot[WIDTH-2:0], q_bit};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          // A zero divisor needs no steps: the result is ready immediately.
          state_next = (b == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend    <= '0;
      divisor     <= '0;
      rem         <= '0;
      quot        <= '0;
      cnt         <= '0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            dividend <= a;
            divisor  <= b;
            rem      <= '0;
            quot     <= '0;
            if (b == '0) begin
              q           <= WIDTH'(DBZ_Q);
              r           <= a;
              div_by_zero <= 1'b1;
              cnt         <= '0;
            end else begin
              div_by_zero <= 1'b0;
              cnt         <= CNT_LAST;
            end
          end
        end
        CALC: begin
          dividend <= {dividend[WIDTH-2:0], 1'b0};
          rem      <= rem_next;
          quot     <= quot_next;
          if (cnt == '0) begin
            q <= quot_next;
            r <= rem_next[WIDTH-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized self-checking bench for div_seq_ctrl at WIDTH=4 and WIDTH=8,
// compared against plain integer division with the q=0, r=a zero-divisor rule.
module tb_div_seq_ctrl;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          in_valid, in_ready, out_valid, out_ready, div_by_zero, busy;
  logic [W-1:0]  a, b, q, r;

  logic          in_valid8, in_ready8, out_valid8, out_ready8, div_by_zero8, busy8;
  logic [W8-1:0] a8, b8, q8, r8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .r(r),
    .div_by_zero(div_by_zero), .busy(busy)
  );

  div_seq_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .q(q8), .r(r8),
    .div_by_zero(div_by_zero8), .busy(busy8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_div(input int unsigned av, input int unsigned bv,
                                  output int unsigned qv, output int unsigned rv);
    if (bv == 0) begin
      qv = 0;
      rv = av;
    end else begin
      qv = av / bv;
      rv = av % bv;
    end
  endfunction

  // keep=1 holds in_valid high and presents the next operands right after acceptance.
  task automatic run_op(input int unsigned av, input int unsigned bv, input int stall,
                        input bit keep, input int unsigned na, input int unsigned nb);
    int unsigned qe, re;
    int n;
    ref_div(av, bv, qe, re);
    a        = W'(av);
    b        = W'(bv);
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    if (keep) begin
      a = W'(na);
      b = W'(nb);
    end else begin
      in_valid = 1'b0;
    end
    n = 0;
    while (!out_valid && n < 40) begin
      check("in_ready_calc", 32'(in_ready), 32'd0);
      check("busy_calc", 32'(busy), 32'd1);
      if (!keep) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), (bv == 0) ? 32'd0 : 32'(W));
    check("q", 32'(q), qe);
    check("r", 32'(r), re);
    check("dbz", 32'(div_by_zero), (bv == 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (!keep) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
      end
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_q", 32'(q), qe);
      check("stall_r", 32'(r), re);
    end
    if (!keep) in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
    check("hold_q", 32'(q), qe);
    check("hold_r", 32'(r), re);
  endtask

  task automatic run_op8(input int unsigned av, input int unsigned bv);
    int unsigned qe, re;
    int n;
    ref_div(av, bv, qe, re);
    a8 = W8'(av);
    b8 = W8'(bv);
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("w8_latency", 32'(n), (bv == 0) ? 32'd0 : 32'(W8));
    check("w8_q", 32'(q8), qe);
    check("w8_r", 32'(r8), re);
    check("w8_dbz", 32'(div_by_zero8), (bv == 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    check("w8_drain", 32'(out_valid8), 32'd0);
  endtask

  initial begin
    in_valid  = 1'b0; a  = '0; b  = '0; out_ready  = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready8", 32'(in_ready8), 32'd1);
    rst = 1'b0;

    run_op(7, 3, 0, 1'b0, 0, 0);
    run_op(9, 0, 0, 1'b0, 0, 0);
    run_op(15, 4, 3, 1'b0, 0, 0);
    run_op(8, 5, 0, 1'b1, 15, 15);
    run_op(15, 15, 0, 1'b0, 0, 0);

    // Reset in the second CALC cycle discards the operation.
    a = 4'd13; b = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_r", 32'(r), 32'd0);
    check("mid_rst_dbz", 32'(div_by_zero), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(13, 2, 0, 1'b0, 0, 0);

    for (int i = 0; i < 16; i++) run_op(i, 3, 0, 1'b0, 0, 0);
    run_op(0, 7, 1, 1'b0, 0, 0);
    run_op(15, 1, 0, 1'b0, 0, 0);
    run_op(0, 0, 2, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      int unsigned ra, rb;
      ra = $urandom_range(0, 15);
      rb = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      run_op(ra, rb, $urandom_range(0, 3), 1'b0, 0, 0);
    end

    run_op8(255, 1);
    run_op8(200, 7);
    run_op8(200, 0);
    for (int i = 0; i < 20; i++) begin
      run_op8($urandom_range(0, 255), $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
